// File: rtl/stream_frame_writer.sv
// stream_frame_writer
// Avalon-ST video sink: accepts RGB444 frame packets delimited by
// startofpacket/endofpacket, checks the frame length against
// IMG_WIDTH*IMG_LENGTH and writes every in-frame pixel to a raster frame
// buffer at address y*IMG_WIDTH+x (kept as a running counter, no multiply).
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   data_in, valid_in   pixel beat from the filter
//   startofpacket_in    first pixel of a frame
//   endofpacket_in      last pixel of a frame
//   ready_out           combinational sink ready (low in reset or on wr_busy)
//   wr_busy             frame buffer stall request
//   wr_en/wr_addr/wr_data  registered frame buffer write port
//   frame_done          one-cycle pulse, good frame completed
//   frame_error         one-cycle pulse, framing error detected
//   frame_count         good frames received (wraps)
//   error_count         framing errors (saturates at 255)
module stream_frame_writer #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_LENGTH = 240,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  startofpacket_in,
  input  logic                  endofpacket_in,
  output logic                  ready_out,
  input  logic                  wr_busy,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic [15:0]           frame_count,
  output logic [7:0]            error_count
);

  localparam int LEN = IMG_WIDTH * IMG_LENGTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LEN - 1);

  typedef enum logic [1:0] {
    WAIT_SOP = 2'd0,
    RECEIVE  = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_error_q, frame_error_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic [7:0]            error_count_q, error_count_d;
  logic                  beat_acc;

  assign ready_out = ~reset & ~wr_busy;
  assign beat_acc  = valid_in & ready_out;

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign frame_count = frame_count_q;
  assign error_count = error_count_q;

  // Next-state, write port and status computation for one accepted beat.
  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;

    if (beat_acc) begin
      if (startofpacket_in) begin
        // An SOP always restarts at pixel 0, whatever state we are in.
        // Outside WAIT_SOP it abandons a frame; SOP+EOP is a one-beat frame.
        // Both conditions together still count as a single error.
        wr_en_d       = 1'b1;
        wr_addr_d     = {ADDR_WIDTH{1'b0}};
        wr_data_d     = data_in;
        pix_cnt_d     = ADDR_WIDTH'(1);
        frame_error_d = (state_q != WAIT_SOP) | endofpacket_in;
        state_d       = endofpacket_in ? WAIT_SOP : RECEIVE;
      end else begin
        case (state_q)
          RECEIVE: begin
            wr_en_d   = 1'b1;
            wr_addr_d = pix_cnt_q;
            wr_data_d = data_in;
            if (endofpacket_in) begin
              state_d = WAIT_SOP;
              if (pix_cnt_q == LAST_ADDR) begin
                frame_done_d = 1'b1;
              end else begin
                frame_error_d = 1'b1;
              end
            end else if (pix_cnt_q == LAST_ADDR) begin
              // Buffer full but no EOP yet: drop the rest of this packet.
              state_d = FLUSH;
            end else begin
              pix_cnt_d = pix_cnt_q + ADDR_WIDTH'(1);
            end
          end
          FLUSH: begin
            if (endofpacket_in) begin
              frame_error_d = 1'b1;
              state_d       = WAIT_SOP;
            end else begin
              state_d = FLUSH;
            end
          end
          default: begin
            // WAIT_SOP: stray beats before an SOP are discarded.
            state_d = WAIT_SOP;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end

    frame_count_d = frame_count_q + {15'd0, frame_done_d};
    if (frame_error_d && (error_count_q != 8'hFF)) begin
      error_count_d = error_count_q + 8'd1;
    end else begin
      error_count_d = error_count_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_SOP;
      pix_cnt_q     <= {ADDR_WIDTH{1'b0}};
      wr_en_q       <= 1'b0;
      wr_addr_q     <= {ADDR_WIDTH{1'b0}};
      wr_data_q     <= {DATA_WIDTH{1'b0}};
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      frame_count_q <= 16'd0;
      error_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      frame_count_q <= frame_count_d;
      error_count_q <= error_count_d;
    end
  end

endmodule

// File: tb/tb_stream_frame_writer.sv
// Bench for stream_frame_writer using a reduced 8x6 frame (LEN=48).
module tb_stream_frame_writer;

  localparam int W   = 8;
  localparam int L   = 6;
  localparam int LEN = W * L;
  localparam int DW  = 12;
  localparam int AW  = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          sop = 1'b0;
  logic          eop = 1'b0;
  logic          ready_out;
  logic          wr_busy = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_done;
  logic          frame_error;
  logic [15:0]   frame_count;
  logic [7:0]    error_count;

  always #5 clk = ~clk;

  stream_frame_writer #(
    .IMG_WIDTH(W), .IMG_LENGTH(L), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .startofpacket_in(sop), .endofpacket_in(eop), .ready_out(ready_out),
    .wr_busy(wr_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_error(frame_error),
    .frame_count(frame_count), .error_count(error_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: cur = beats seen since the last SOP (-1 = no frame open).
  int          cur = -1;
  int          m_fc = 0;
  int          m_ec = 0;
  logic        e_wr = 1'b0, e_done = 1'b0, e_err = 1'b0;
  int          e_addr = 0;
  logic [11:0] e_data = '0;

  // Observed statistics, cleared per scenario.
  int          n_wr = 0, n_done = 0, n_err = 0, first_addr = -1;
  logic [11:0] mem [0:63];
  bit          rnd_mode = 0, gap_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int idx;
    if (reset) begin
      cur = -1; m_fc = 0; m_ec = 0;
      e_wr = 1'b0; e_done = 1'b0; e_err = 1'b0; e_addr = 0; e_data = '0;
    end else begin
      e_wr = 1'b0; e_done = 1'b0; e_err = 1'b0;
      if (valid_in && !wr_busy && (sop || cur >= 0)) begin
        idx   = sop ? 0 : cur;
        e_err = sop && (cur >= 0);
        if (idx < LEN) begin
          e_wr = 1'b1; e_addr = idx; e_data = data_in;
        end
        if (eop) begin
          if (idx == LEN - 1 && !e_err) e_done = 1'b1;
          else e_err = 1'b1;
          cur = -1;
        end else begin
          cur = (idx + 1 > LEN) ? LEN : idx + 1;
        end
        if (e_done) m_fc = (m_fc + 1) % 65536;
        if (e_err && m_ec < 255) m_ec++;
      end
    end
  endtask

  // Model updates on the active edge; DUT is compared on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("ready_out", ready_out, {31'd0, !reset && !wr_busy});
      chk("wr_en", wr_en, e_wr);
      if (e_wr) begin
        chk("wr_addr", wr_addr, e_addr);
        chk("wr_data", wr_data, e_data);
      end
      chk("frame_done", frame_done, e_done);
      chk("frame_error", frame_error, e_err);
      chk("frame_count", frame_count, m_fc);
      chk("error_count", error_count, m_ec);
      if (wr_en === 1'b1) begin
        n_wr++;
        if (first_addr < 0) first_addr = int'(wr_addr);
        mem[wr_addr] = wr_data;
      end
      if (frame_done === 1'b1) n_done++;
      if (frame_error === 1'b1) n_err++;
    end
  end

  task automatic clear_stats();
    n_wr = 0; n_done = 0; n_err = 0; first_addr = -1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0; sop = 1'b0; eop = 1'b0;
    if (!rnd_mode) wr_busy = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic beat(input logic s, input logic e, input logic [11:0] d);
    int  guard = 0;
    bit  acc;
    valid_in = 1'b1; sop = s; eop = e; data_in = d;
    forever begin
      wr_busy = rnd_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(posedge clk);
      acc = !wr_busy && !reset;
      #1;
      if (acc) break;
      guard++;
      if (guard > 200) begin
        tests++; fails++;
        $display("FAIL beat_accept: got no acceptance expected acceptance within 200 cycles");
        break;
      end
    end
    valid_in = 1'b0; sop = 1'b0; eop = 1'b0;
    if (gap_mode && $urandom_range(0, 2) == 0) begin
      wr_busy = rnd_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [11:0] pix(input int i, input int pat);
    if (pat == 0) return 12'h555;
    if (pat == 1) return (((i / W) % 5) == 0) ? 12'hFFF : 12'h000;
    return 12'(i * 37 + 3);
  endfunction

  task automatic send_frame(input int n, input int pat, input bit with_sop, input bit with_eop);
    for (int i = 0; i < n; i++) begin
      beat(with_sop && (i == 0), with_eop && (i == n - 1), pix(i, pat));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready_out, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_error_count", error_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // Clean frame
    clear_stats();
    send_frame(LEN, 0, 1, 1); idle(2);
    chk("clean_writes", n_wr, 48);
    chk("clean_first_addr", first_addr, 0);
    chk("clean_done", n_done, 1);
    chk("clean_err", n_err, 0);
    chk("clean_fc", frame_count, 1);
    chk("clean_ec", error_count, 0);

    // Row pattern: lines 0 and 5 bright
    clear_stats();
    send_frame(LEN, 1, 1, 1); idle(2);
    chk("row_mem0", mem[0], 12'hFFF);
    chk("row_mem8", mem[8], 12'h000);
    chk("row_mem39", mem[39], 12'h000);
    chk("row_mem40", mem[40], 12'hFFF);
    chk("row_mem47", mem[47], 12'hFFF);
    chk("row_done", n_done, 1);
    chk("row_fc", frame_count, 2);

    // Garbage before SOP
    clear_stats();
    for (int i = 0; i < 10; i++) beat(1'b0, 1'b0, 12'hABC);
    send_frame(LEN, 2, 1, 1); idle(2);
    chk("garbage_writes", n_wr, 48);
    chk("garbage_first_addr", first_addr, 0);
    chk("garbage_first_data", mem[0], 12'h003);
    chk("garbage_fc", frame_count, 3);

    // Short frame then clean frame
    clear_stats();
    send_frame(10, 2, 1, 1); idle(2);
    chk("short_writes", n_wr, 10);
    chk("short_err", n_err, 1);
    chk("short_ec", error_count, 1);
    chk("short_fc", frame_count, 3);
    send_frame(LEN, 2, 1, 1); idle(2);
    chk("after_short_fc", frame_count, 4);

    // Long frame
    clear_stats();
    send_frame(LEN + 5, 2, 1, 1); idle(2);
    chk("long_writes", n_wr, 48);
    chk("long_done", n_done, 0);
    chk("long_err", n_err, 1);
    chk("long_ec", error_count, 2);
    chk("long_fc", frame_count, 4);

    // SOP mid-frame restarts at pixel 0
    clear_stats();
    send_frame(5, 2, 1, 0);
    send_frame(LEN, 2, 1, 1); idle(2);
    chk("midsop_writes", n_wr, 53);
    chk("midsop_err", n_err, 1);
    chk("midsop_done", n_done, 1);
    chk("midsop_ec", error_count, 3);
    chk("midsop_fc", frame_count, 5);

    // Lone SOP+EOP beat
    beat(1'b1, 1'b1, 12'h123); idle(2);
    chk("sopeop_ec", error_count, 4);

    // Stalls and gaps, then reset mid-frame
    rnd_mode = 1; gap_mode = 1;
    clear_stats();
    send_frame(LEN, 2, 1, 1); idle(2);
    chk("rnd_writes", n_wr, 48);
    chk("rnd_fc", frame_count, 6);
    send_frame(20, 2, 1, 0);
    reset = 1'b1; valid_in = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_wr_data", wr_data, 0);
    chk("midrst_fc", frame_count, 0);
    chk("midrst_ec", error_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_stats();
    send_frame(LEN, 2, 1, 1); idle(2);
    chk("postrst_first_addr", first_addr, 0);
    chk("postrst_done", n_done, 1);
    chk("postrst_fc", frame_count, 1);
    chk("postrst_ec", error_count, 0);

    // error_count saturation
    rnd_mode = 0; gap_mode = 0;
    for (int i = 0; i < 260; i++) beat(1'b1, 1'b1, 12'h0F0);
    idle(2);
    chk("sat_ec", error_count, 255);
    chk("sat_fc", frame_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_frame_writer.md
# stream_frame_writer

Avalon-ST video sink that terminates the pixel stream leaving the edge filter. It consumes 12-bit RGB444 frame packets framed by startofpacket/endofpacket, checks framing against the configured frame size, and writes each pixel to a raster frame buffer through a simple write port. It sits between the filter pipeline and the display frame buffer, and is the receive-side counterpart of the video source driving the filter.

## Interface

Parameters:
- IMG_WIDTH, 320, pixels per line
- IMG_LENGTH, 240, lines per frame
- DATA_WIDTH, 12, pixel width (RGB444)
- ADDR_WIDTH, 17, frame buffer address width; must satisfy 2^ADDR_WIDTH >= IMG_WIDTH*IMG_LENGTH

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- data_in  in  DATA_WIDTH  pixel data from the filter
- valid_in  in  1  upstream beat valid
- startofpacket_in  in  1  first pixel of frame
- endofpacket_in  in  1  last pixel of frame
- ready_out  out  1  sink ready toward the filter
- wr_busy  in  1  frame buffer stall request
- wr_en  out  1  frame buffer write strobe
- wr_addr  out  ADDR_WIDTH  raster address, y*IMG_WIDTH+x
- wr_data  out  DATA_WIDTH  pixel to write
- frame_done  out  1  one-cycle pulse: good frame completed
- frame_error  out  1  one-cycle pulse: framing error detected
- frame_count  out  16  good frames received, wraps
- error_count  out  8  framing errors, saturates at 255

## Operation

- LEN = IMG_WIDTH*IMG_LENGTH (76800 at defaults). Beat accepted = valid_in & ready_out.
- ready_out = ~reset & ~wr_busy. Combinational; no other backpressure.
- pix_cnt: running write address counter. No multiplier is used.
- States:
  - WAIT_SOP (reset state). Accepted beat without SOP is discarded and not written. Accepted beat with SOP writes address 0, sets pix_cnt=1, and goes to RECEIVE. If the SOP beat also carries EOP: write it, pulse frame_error, stay in WAIT_SOP.
  - RECEIVE. Each accepted beat is written at pix_cnt, then pix_cnt increments.
    - SOP mid-frame: pulse frame_error. Treat the beat as pixel 0 of a new frame (write addr 0, pix_cnt=1). Stay in RECEIVE.
    - EOP at pix_cnt==LEN-1: write, pulse frame_done, increment frame_count, go to WAIT_SOP.
    - EOP at pix_cnt<LEN-1 (short frame): write, pulse frame_error, go to WAIT_SOP.
    - Beat at pix_cnt==LEN-1 without EOP: write, go to FLUSH.
  - FLUSH. Accepted beats are discarded.
    - EOP accepted: pulse frame_error, go to WAIT_SOP.
    - SOP accepted: pulse frame_error, start a new frame exactly as in WAIT_SOP.
- A beat with SOP and EOP both set in RECEIVE or FLUSH counts as one error.
- Every frame_error pulse increments error_count, saturating at 255.

## Timing

- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_error=0, frame_count=0, error_count=0, pix_cnt=0, state WAIT_SOP. ready_out is 0 while reset is high.
- Reset mid-frame abandons the frame with no error counted. The first post-reset SOP writes address 0.
- Write latency is 1 cycle: beat accepted in cycle n gives wr_en/wr_addr/wr_data registered valid in cycle n+1.
- frame_done and frame_error are registered and coincide with the wr_en of the terminating beat.
- wr_busy rising in cycle n forces ready_out low in cycle n. A write from a beat accepted in cycle n-1 still appears in cycle n; the frame buffer must absorb that one write.
- Throughput is one pixel per clock while valid_in=1 and wr_busy=0. Gaps in valid_in do not disturb pix_cnt or state.
- Only the EOP-at-LEN-1 case qualifies as a good frame.

## Test plan

- Clean frame: 76800 beats of 12'h555, SOP on beat 0, EOP on beat 76799 -> 76800 writes, addresses 0..76799 in order, one frame_done, frame_count=1, error_count=0.
- Row pattern: lines where y%5==0 are 12'hFFF, all others 12'h000 -> write at addr 1600 has data FFF, addr 1601+319=1920 has data 000, addr 1920..2239 data 000. frame_done once.
- Garbage before SOP: 10 beats without SOP, then a clean frame -> first write is addr 0 and comes from the SOP beat; total 76800 writes.
- Short frame (EOP on beat 99), then a clean frame -> 100 writes at 0..99, frame_error pulse, error_count=1. Second frame completes with frame_done and frame_count=1.
- Long frame: 76805 beats, EOP on the last -> 76800 writes, 5 beats discarded, frame_error at EOP, frame_count unchanged.
- wr_busy toggled pseudo-randomly and valid_in gapped; reset asserted at pixel 500 of one frame -> ready_out low whenever wr_busy=1, no dropped or duplicated addresses. After reset all outputs are 0, and the next frame starts at addr 0 and ends with frame_done.
